// File: rtl/gate_alu_pkg.sv
// ----------------------------------------------------------------------------
// gate_alu_pkg
// Shared definitions for the gate ALU pipeline:
//   op_t           3-bit function-select type
//   OP_AND..OP_BUF function-select encodings
// ----------------------------------------------------------------------------
package gate_alu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_NAND = 3'd2;
    localparam op_t OP_NOR  = 3'd3;
    localparam op_t OP_XOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_NOT  = 3'd6;  // NOT A, B ignored
    localparam op_t OP_BUF  = 3'd7;  // BUF A, B ignored

endpackage

// File: rtl/gate_alu_core.sv
// ----------------------------------------------------------------------------
// gate_alu_core
// Purely combinational gate function plus result flags.
// Ports:
//   i_a      in  WIDTH            operand A
//   i_b      in  WIDTH            operand B
//   i_op     in  op_t             function select
//   o_result out WIDTH            f(A, B, op)
//   o_zero   out 1                o_result == 0
//   o_parity out 1                XOR-reduce of o_result
//   o_ones   out $clog2(WIDTH+1)  popcount of o_result
// ----------------------------------------------------------------------------
module gate_alu_core
    import gate_alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ONES_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    input  op_t               i_op,
    output logic [WIDTH-1:0]  o_result,
    output logic              o_zero,
    output logic              o_parity,
    output logic [ONES_W-1:0] o_ones
);

    logic [WIDTH-1:0]  w_res;
    logic [ONES_W-1:0] w_ones;

    always_comb begin
        w_res = '0;
        unique case (i_op)
            OP_AND:  w_res = i_a & i_b;
            OP_OR:   w_res = i_a | i_b;
            OP_NAND: w_res = ~(i_a & i_b);
            OP_NOR:  w_res = ~(i_a | i_b);
            OP_XOR:  w_res = i_a ^ i_b;
            OP_XNOR: w_res = ~(i_a ^ i_b);
            OP_NOT:  w_res = ~i_a;
            OP_BUF:  w_res = i_a;
            default: w_res = i_a;
        endcase
    end

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_ones = w_ones + ONES_W'(w_res[i]);
        end
    end

    assign o_result = w_res;
    assign o_zero   = (w_res == '0);
    assign o_parity = ^w_res;
    assign o_ones   = w_ones;

endmodule

// File: rtl/gate_alu_pipe.sv
// ----------------------------------------------------------------------------
// gate_alu_pipe
// Registered bitwise logic unit with a valid/ready handshake on both sides,
// 1-cycle latency, full 1 beat/cycle throughput, an optional feedback
// accumulator and a wrapping completed-transfer counter.
// Ports:
//   clk_in        in  1                clock, rising edge
//   rst_in        in  1                synchronous active-high reset
//   a_in, b_in    in  WIDTH            operands
//   op_in         in  3                function select (see gate_alu_pkg)
//   acc_mode_in   in  1                use accumulator in place of a_in
//   acc_clr_in    in  1                synchronous accumulator clear
//   valid_in      in  1                operand beat valid
//   ready_out     out 1                beat can be accepted this cycle
//   result_out    out WIDTH            registered result
//   zero_out      out 1                result_out == 0
//   parity_out    out 1                XOR-reduce of result_out
//   ones_out      out $clog2(WIDTH+1)  popcount of result_out
//   valid_out     out 1                result and flags valid
//   ready_in      in  1                consumer takes the result this cycle
//   xfer_cnt_out  out CNT_W            completed output transfers (wraps)
// ----------------------------------------------------------------------------
module gate_alu_pipe
    import gate_alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ACC_EN = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [WIDTH-1:0]             a_in,
    input  logic [WIDTH-1:0]             b_in,
    input  logic [2:0]                   op_in,
    input  logic                         acc_mode_in,
    input  logic                         acc_clr_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    output logic [WIDTH-1:0]             result_out,
    output logic                         zero_out,
    output logic                         parity_out,
    output logic [$clog2(WIDTH+1)-1:0]   ones_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic [CNT_W-1:0]             xfer_cnt_out
);

    localparam int unsigned ONES_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_parity;
    logic [ONES_W-1:0] r_ones;
    logic              r_valid;
    logic [WIDTH-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_ready;
    logic              w_accept;
    logic              w_drain;
    logic [WIDTH-1:0]  w_acc_eff;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_res;
    logic              w_zero;
    logic              w_parity;
    logic [ONES_W-1:0] w_ones;

    // Output register is free or being emptied this cycle: no bubble on drain+load.
    assign w_ready  = !r_valid || ready_in;
    assign w_accept = valid_in && w_ready;
    assign w_drain  = r_valid && ready_in;

    // A same-cycle clear makes the accumulator read as zero for this beat.
    assign w_acc_eff = acc_clr_in ? '0 : r_acc;
    assign w_a       = ((ACC_EN != 0) && acc_mode_in) ? w_acc_eff : a_in;

    gate_alu_core #(
        .WIDTH  (WIDTH),
        .ONES_W (ONES_W)
    ) u_core (
        .i_a      (w_a),
        .i_b      (b_in),
        .i_op     (op_t'(op_in)),
        .o_result (w_res),
        .o_zero   (w_zero),
        .o_parity (w_parity),
        .o_ones   (w_ones)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_parity <= 1'b0;
            r_ones   <= '0;
            r_valid  <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_result <= w_res;
                r_zero   <= w_zero;
                r_parity <= w_parity;
                r_ones   <= w_ones;
                r_valid  <= 1'b1;
            end else if (w_drain) begin
                r_valid  <= 1'b0;
            end

            if (w_drain) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Load wins over clear; with ACC_EN=0 the accumulator stays at reset value.
            if (ACC_EN != 0) begin
                if (w_accept) begin
                    r_acc <= w_res;
                end else if (acc_clr_in) begin
                    r_acc <= '0;
                end
            end
        end
    end

    assign ready_out    = w_ready;
    assign result_out   = r_result;
    assign zero_out     = r_zero;
    assign parity_out   = r_parity;
    assign ones_out     = r_ones;
    assign valid_out    = r_valid;
    assign xfer_cnt_out = r_cnt;

endmodule

// File: tb/tb_gate_alu_pipe.sv
module tb_gate_alu_pipe;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] a_in = '0, b_in = '0;
    logic [2:0] op_in = '0;
    logic       acc_mode_in = 1'b0, acc_clr_in = 1'b0, valid_in = 1'b0, ready_in = 1'b1;
    logic       ready_out, zero_out, parity_out, valid_out;
    logic [7:0] result_out;
    logic [3:0] ones_out;
    logic [7:0] xfer_cnt_out;

    gate_alu_pipe #(.WIDTH(8), .ACC_EN(1), .CNT_W(8)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .a_in         (a_in),
        .b_in         (b_in),
        .op_in        (op_in),
        .acc_mode_in  (acc_mode_in),
        .acc_clr_in   (acc_clr_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .result_out   (result_out),
        .zero_out     (zero_out),
        .parity_out   (parity_out),
        .ones_out     (ones_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .xfer_cnt_out (xfer_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Reference model: independent of the RTL structure.
    function automatic logic [7:0] ref_f(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    typedef struct {
        logic [7:0] res;
        logic       zero;
        logic       par;
        logic [3:0] ones;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_acc = '0;
    logic [7:0] m_cnt = '0;

    // Scoreboard: decisions for the coming edge are taken mid-cycle.
    always @(negedge clk_in) begin
        exp_t       e;
        logic [7:0] a_eff;
        if (rst_in) begin
            sb.delete();
            m_acc = '0;
            m_cnt = '0;
        end else begin
            check("ready_out", 32'(ready_out), 32'(!valid_out || ready_in));
            if (valid_out && ready_in) begin
                check("xfer_cnt", 32'(xfer_cnt_out), 32'(m_cnt));
                m_cnt = m_cnt + 8'd1;
                if (sb.size() == 0) begin
                    check("sb_nonempty", 32'(0), 32'(1));
                end else begin
                    e = sb.pop_front();
                    check("sb_result", 32'(result_out), 32'(e.res));
                    check("sb_zero", 32'(zero_out), 32'(e.zero));
                    check("sb_parity", 32'(parity_out), 32'(e.par));
                    check("sb_ones", 32'(ones_out), 32'(e.ones));
                end
            end
            if (valid_in && ready_out) begin
                a_eff  = acc_mode_in ? (acc_clr_in ? 8'h00 : m_acc) : a_in;
                e.res  = ref_f(op_in, a_eff, b_in);
                e.zero = (e.res == 8'h00);
                e.par  = ^e.res;
                e.ones = 4'($countones(e.res));
                sb.push_back(e);
                m_acc  = e.res;
            end else if (acc_clr_in) begin
                m_acc = '0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] c0;

    initial begin
        vecs[0] = '{3'd0, 8'hA5, 8'h3C, 8'h24};
        vecs[1] = '{3'd1, 8'hA5, 8'h3C, 8'hBD};
        vecs[2] = '{3'd2, 8'hA5, 8'h3C, 8'hDB};
        vecs[3] = '{3'd3, 8'hA5, 8'h3C, 8'h42};
        vecs[4] = '{3'd4, 8'hA5, 8'h3C, 8'h99};
        vecs[5] = '{3'd5, 8'hA5, 8'h3C, 8'h66};
        vecs[6] = '{3'd6, 8'hA5, 8'h3C, 8'h5A};
        vecs[7] = '{3'd7, 8'hA5, 8'h3C, 8'hA5};

        // Reset values
        valid_in = 1'b1;  // beats ignored during reset
        step();
        step();
        check("rst_valid", 32'(valid_out), 32'(0));
        check("rst_result", 32'(result_out), 32'(0));
        check("rst_zero", 32'(zero_out), 32'(1));
        check("rst_parity", 32'(parity_out), 32'(0));
        check("rst_ones", 32'(ones_out), 32'(0));
        check("rst_cnt", 32'(xfer_cnt_out), 32'(0));
        check("rst_ready", 32'(ready_out), 32'(1));
        valid_in = 1'b0;
        rst_in   = 1'b0;
        step();

        // All ops, result 1 cycle after accept
        for (int i = 0; i < 8; i++) begin
            op_in = vecs[i].op; a_in = vecs[i].a; b_in = vecs[i].b; valid_in = 1'b1;
            step();
            valid_in = 1'b0;
            check($sformatf("op%0d_valid", i), 32'(valid_out), 32'(1));
            check($sformatf("op%0d_result", i), 32'(result_out), 32'(vecs[i].exp));
        end
        step();

        // Flags
        op_in = 3'd4; a_in = 8'h55; b_in = 8'h55; valid_in = 1'b1;
        step();
        check("flag_xor_res", 32'(result_out), 32'(8'h00));
        check("flag_xor_zero", 32'(zero_out), 32'(1));
        check("flag_xor_par", 32'(parity_out), 32'(0));
        check("flag_xor_ones", 32'(ones_out), 32'(0));
        op_in = 3'd1; a_in = 8'h07; b_in = 8'h00;
        step();
        valid_in = 1'b0;
        check("flag_or_zero", 32'(zero_out), 32'(0));
        check("flag_or_ones", 32'(ones_out), 32'(3));
        check("flag_or_par", 32'(parity_out), 32'(1));
        step();

        // Backpressure
        c0 = xfer_cnt_out;
        ready_in = 1'b0;
        op_in = 3'd1; a_in = 8'h11; b_in = 8'h22; valid_in = 1'b1;
        step();
        op_in = 3'd0; a_in = 8'h44; b_in = 8'h0F;
        for (int k = 0; k < 5; k++) begin
            check("bp_ready", 32'(ready_out), 32'(0));
            check("bp_valid", 32'(valid_out), 32'(1));
            check("bp_hold", 32'(result_out), 32'(8'h33));
            check("bp_cnt", 32'(xfer_cnt_out), 32'(c0));
            step();
        end
        ready_in = 1'b1;
        #1;
        check("bp_ready_rel", 32'(ready_out), 32'(1));
        step();
        valid_in = 1'b0;
        check("bp_next", 32'(result_out), 32'(8'h04));
        check("bp_next_valid", 32'(valid_out), 32'(1));
        check("bp_cnt1", 32'(xfer_cnt_out), 32'(c0 + 8'd1));
        step();
        check("bp_cnt2", 32'(xfer_cnt_out), 32'(c0 + 8'd2));
        check("bp_empty", 32'(valid_out), 32'(0));

        // Accumulator
        acc_clr_in = 1'b1;
        step();
        acc_clr_in = 1'b0; acc_mode_in = 1'b1; op_in = 3'd4; a_in = 8'hFF; valid_in = 1'b1;
        b_in = 8'h01; step(); check("acc_1", 32'(result_out), 32'(8'h01));
        b_in = 8'h02; step(); check("acc_2", 32'(result_out), 32'(8'h03));
        b_in = 8'h04; step(); check("acc_3", 32'(result_out), 32'(8'h07));
        acc_clr_in = 1'b1; op_in = 3'd1; b_in = 8'h10;
        step(); check("acc_clr_load", 32'(result_out), 32'(8'h10));
        acc_clr_in = 1'b0; acc_mode_in = 1'b0; valid_in = 1'b0;
        step();

        // Streaming with counter wrap (CNT_W=8)
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        for (int i = 0; i < 256; i++) begin
            a_in = 8'($urandom); b_in = 8'($urandom); op_in = 3'($urandom_range(0, 7));
            valid_in = 1'b1;
            step();
            check("st_valid", 32'(valid_out), 32'(1));
            if (i == 255) check("st_cnt255", 32'(xfer_cnt_out), 32'(8'hFF));
        end
        valid_in = 1'b0;
        step();
        check("st_wrap", 32'(xfer_cnt_out), 32'(8'h00));

        // Reset mid-transfer
        ready_in = 1'b0; op_in = 3'd7; a_in = 8'hFF; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        check("mr_pending", 32'(result_out), 32'(8'hFF));
        rst_in = 1'b1;
        step();
        check("mr_valid", 32'(valid_out), 32'(0));
        check("mr_result", 32'(result_out), 32'(0));
        check("mr_zero", 32'(zero_out), 32'(1));
        check("mr_cnt", 32'(xfer_cnt_out), 32'(0));
        check("mr_ready", 32'(ready_out), 32'(1));
        rst_in = 1'b0; ready_in = 1'b1;
        acc_mode_in = 1'b1; op_in = 3'd7; a_in = 8'hAA; valid_in = 1'b1;
        step();
        check("mr_acc", 32'(result_out), 32'(8'h00));
        acc_mode_in = 1'b0; valid_in = 1'b0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        check("sb_drained", 32'(sb.size()), 32'(0));
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
